// File: rtl/lbp_engine_param.sv
// ---------------------------------------------------------------------------
// lbp_engine_param
//
// Purpose:
//   Computes an 8-bit Local Binary Pattern code for every centre pixel of a
//   gray image held in an external memory. The engine streams the image one
//   column at a time: for each interior row it reads the three vertically
//   adjacent pixels of every column and shifts them into a 3x3 window. Each
//   completed window yields one code, written to the lbp result memory. With
//   WRITE_BORDER=1 the border pixels are written as 0, so the whole result
//   image is produced in raster order.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset; aborts any frame in progress
//   gray_ready  source ready; starts a frame from IDLE and gates every read
//   mode        0 = plain compare, 1 = compare against centre + thr
//   thr         threshold for mode 1 (latched with mode at frame start)
//   gray_req    read request for gray_addr
//   gray_addr   read address, y*IMG_W + x
//   gray_data   read data, captured at the edge ending a gray_req cycle
//   lbp_valid   single-cycle write strobe
//   lbp_addr    write address
//   lbp_data    LBP code
//   finish      frame complete; held until reset
// ---------------------------------------------------------------------------
module lbp_engine_param #(
   parameter int IMG_W        = 128,
   parameter int IMG_H        = 128,
   parameter int PIX_W        = 8,
   parameter int ADDR_W       = 14,
   parameter int WRITE_BORDER = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   input  logic              mode,
   input  logic [PIX_W-1:0]  thr,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic [PIX_W-1:0]  gray_data,
   output logic              lbp_valid,
   output logic [ADDR_W-1:0] lbp_addr,
   output logic [7:0]        lbp_data,
   output logic              finish
);

   localparam int XW = $clog2(IMG_W) + 1;
   localparam int YW = $clog2(IMG_H) + 1;

   localparam logic [XW-1:0]     X_ONE    = XW'(1);
   localparam logic [XW-1:0]     X_TWO    = XW'(2);
   localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);
   localparam logic [YW-1:0]     Y_ONE    = YW'(1);
   localparam logic [YW-1:0]     Y_LASTIN = YW'(IMG_H - 2);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(2 * IMG_W);
   localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 1);
   localparam logic              WB        = (WRITE_BORDER != 0);

   typedef enum logic [2:0] {
      IDLE,
      TOP,
      ROW_FETCH,
      ROW_WRITE,
      BOT,
      DONE
   } state_t;

   state_t                          state_q, state_d;
   logic [XW-1:0]                   x_q, x_d;
   logic [YW-1:0]                   y_q, y_d;
   logic [1:0]                      k_q, k_d;
   logic [ADDR_W-1:0]               rowAddr_q, rowAddr_d;
   logic                            mode_q, mode_d;
   logic [PIX_W-1:0]                thr_q, thr_d;
   logic [PIX_W-1:0]                colBuf0_q, colBuf0_d;
   logic [PIX_W-1:0]                colBuf1_q, colBuf1_d;
   logic [2:0][2:0][PIX_W-1:0]      win_q, win_d;
   logic                            lbpValid_q, lbpValid_d;
   logic [ADDR_W-1:0]               lbpAddr_q, lbpAddr_d;
   logic [7:0]                      lbpData_q, lbpData_d;
   logic                            finish_q, finish_d;

   logic [ADDR_W-1:0]               rowOff;
   logic [ADDR_W-1:0]               readAddr;
   logic [2:0][PIX_W-1:0]           newCol;
   logic [2:0][2:0][PIX_W-1:0]      winNext;
   logic [PIX_W:0]                  limit;
   logic [7:0]                      lbpCode;

   // One extra bit keeps centre + thr from wrapping, so a saturated limit
   // simply makes every neighbour compare false.
   function automatic logic geLimit(input logic [PIX_W-1:0] p,
                                    input logic [PIX_W:0]   lim);
      return ({1'b0, p} >= lim);
   endfunction

   // Read address for phase k of column x: rows y-1, y, y+1 in turn.
   // rowAddr_q holds the address of (y,0), so the phase offset is added to
   // the row above.
   always_comb begin
      rowOff = '0;
      case (k_q)
         2'd1:    rowOff = ROW_STEP;
         2'd2:    rowOff = ROW_STEP2;
         default: rowOff = '0;
      endcase
      readAddr = rowAddr_q - ROW_STEP + rowOff + ADDR_W'(x_q);
   end

   // The third read of a column arrives on gray_data; together with the two
   // buffered reads it forms the newest window column. The code is computed
   // from the window as it will look after that shift, so the centre write
   // can be registered on the same edge.
   always_comb begin
      newCol[0] = colBuf0_q;
      newCol[1] = colBuf1_q;
      newCol[2] = gray_data;
      for (int r = 0; r < 3; r++) begin
         winNext[r][0] = win_q[r][1];
         winNext[r][1] = win_q[r][2];
         winNext[r][2] = newCol[r];
      end
      limit = {1'b0, winNext[1][1]} + (mode_q ? {1'b0, thr_q} : '0);
      lbpCode[0] = geLimit(winNext[0][0], limit);
      lbpCode[1] = geLimit(winNext[0][1], limit);
      lbpCode[2] = geLimit(winNext[0][2], limit);
      lbpCode[3] = geLimit(winNext[1][0], limit);
      lbpCode[4] = geLimit(winNext[1][2], limit);
      lbpCode[5] = geLimit(winNext[2][0], limit);
      lbpCode[6] = geLimit(winNext[2][1], limit);
      lbpCode[7] = geLimit(winNext[2][2], limit);
   end

   // Next-state logic. Nothing advances while gray_ready is low outside
   // IDLE/DONE; a write registered on the previous edge has already been
   // presented for its single cycle, so holding only drops the strobe.
   // Centre writes are registered on the edge that completes a column, which
   // places them in the cycle of the next column's first read. The left
   // border write rides on the first read of a row, the right border write
   // gets its own ROW_WRITE cycle.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      k_d        = k_q;
      rowAddr_d  = rowAddr_q;
      mode_d     = mode_q;
      thr_d      = thr_q;
      colBuf0_d  = colBuf0_q;
      colBuf1_d  = colBuf1_q;
      win_d      = win_q;
      lbpValid_d = 1'b0;
      lbpAddr_d  = lbpAddr_q;
      lbpData_d  = lbpData_q;
      gray_req   = 1'b0;
      gray_addr  = '0;

      unique case (state_q)
         IDLE: begin
            if (gray_ready) begin
               mode_d = mode;
               thr_d  = thr;
               x_d    = '0;
               k_d    = '0;
               if (WB) begin
                  y_d       = '0;
                  rowAddr_d = '0;
                  state_d   = TOP;
               end else begin
                  y_d       = Y_ONE;
                  rowAddr_d = ROW_STEP;
                  state_d   = ROW_FETCH;
               end
            end
         end

         TOP: begin
            if (gray_ready) begin
               lbpValid_d = 1'b1;
               lbpAddr_d  = rowAddr_q + ADDR_W'(x_q);
               lbpData_d  = 8'h00;
               if (x_q == X_LAST) begin
                  x_d       = '0;
                  y_d       = Y_ONE;
                  rowAddr_d = ROW_STEP;
                  state_d   = ROW_FETCH;
               end else begin
                  x_d = x_q + X_ONE;
               end
            end
         end

         ROW_FETCH: begin
            gray_addr = readAddr;
            gray_req  = gray_ready;
            if (gray_ready) begin
               case (k_q)
                  2'd0: begin
                     colBuf0_d = gray_data;
                     k_d       = 2'd1;
                     if (WB && (x_q == '0)) begin
                        lbpValid_d = 1'b1;
                        lbpAddr_d  = rowAddr_q;
                        lbpData_d  = 8'h00;
                     end
                  end
                  2'd1: begin
                     colBuf1_d = gray_data;
                     k_d       = 2'd2;
                  end
                  default: begin
                     win_d = winNext;
                     k_d   = 2'd0;
                     if (x_q >= X_TWO) begin
                        lbpValid_d = 1'b1;
                        lbpAddr_d  = rowAddr_q + ADDR_W'(x_q) - A_ONE;
                        lbpData_d  = lbpCode;
                     end
                     if (x_q == X_LAST) begin
                        state_d = ROW_WRITE;
                     end else begin
                        x_d = x_q + X_ONE;
                     end
                  end
               endcase
            end
         end

         ROW_WRITE: begin
            if (gray_ready) begin
               if (WB) begin
                  lbpValid_d = 1'b1;
                  lbpAddr_d  = rowAddr_q + LAST_COL;
                  lbpData_d  = 8'h00;
               end
               x_d = '0;
               k_d = '0;
               if (y_q == Y_LASTIN) begin
                  if (WB) begin
                     y_d       = y_q + Y_ONE;
                     rowAddr_d = rowAddr_q + ROW_STEP;
                     state_d   = BOT;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  y_d       = y_q + Y_ONE;
                  rowAddr_d = rowAddr_q + ROW_STEP;
                  state_d   = ROW_FETCH;
               end
            end
         end

         BOT: begin
            if (gray_ready) begin
               lbpValid_d = 1'b1;
               lbpAddr_d  = rowAddr_q + ADDR_W'(x_q);
               lbpData_d  = 8'h00;
               if (x_q == X_LAST) begin
                  state_d = DONE;
               end else begin
                  x_d = x_q + X_ONE;
               end
            end
         end

         DONE: begin
            state_d = DONE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // finish follows the cycle that carries the final write strobe.
      finish_d = finish_q | ((state_d == DONE) && !lbpValid_d);
   end

   // State and datapath registers, all cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         k_q        <= '0;
         rowAddr_q  <= '0;
         mode_q     <= 1'b0;
         thr_q      <= '0;
         colBuf0_q  <= '0;
         colBuf1_q  <= '0;
         win_q      <= '0;
         lbpValid_q <= 1'b0;
         lbpAddr_q  <= '0;
         lbpData_q  <= '0;
         finish_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         k_q        <= k_d;
         rowAddr_q  <= rowAddr_d;
         mode_q     <= mode_d;
         thr_q      <= thr_d;
         colBuf0_q  <= colBuf0_d;
         colBuf1_q  <= colBuf1_d;
         win_q      <= win_d;
         lbpValid_q <= lbpValid_d;
         lbpAddr_q  <= lbpAddr_d;
         lbpData_q  <= lbpData_d;
         finish_q   <= finish_d;
      end
   end

   assign lbp_valid = lbpValid_q;
   assign lbp_addr  = lbpAddr_q;
   assign lbp_data  = lbpData_q;
   assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_engine_param.sv
// ---------------------------------------------------------------------------
// tb_lbp_engine_param
//
// Two engines share one clock: dutA is a 6x5 image with border writes, dutB
// a 5x4 ramp image without them. Gray memories answer reads combinationally;
// lbp memories capture on the falling edge inside the tick task.
// ---------------------------------------------------------------------------
module tb_lbp_engine_param;

   localparam int AW = 6;
   localparam int AH = 5;
   localparam int BW = 5;
   localparam int BH = 4;
   localparam int BOUND_A = (AH - 2) * (3 * AW + 4) + 2 * AW + 8;
   localparam int BOUND_B = (BH - 2) * (3 * BW + 4) + 2 * BW + 8;

   typedef logic [7:0] img_t [32];

   logic       clk = 1'b0;
   logic       resetA, readyA, modeA, reqA, validA, finishA;
   logic [7:0] thrA, dataA, wdataA;
   logic [4:0] addrA, waddrA;
   logic       resetB, readyB, modeB, reqB, validB, finishB;
   logic [7:0] thrB, dataB, wdataB;
   logic [4:0] addrB, waddrB;

   img_t grayA, grayB, lbpA, lbpB;
   int   wcntA [32];
   int   wcntB [32];
   int   lastWA, lastWB, orderErrA, orderErrB, stallErrA;
   int   readCntA, readCntB, lastWrCycA, lastWrCycB, finCycA, finCycB;
   int   cycle;
   int   checkCount = 0;
   int   errorCount = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   lbp_engine_param #(
      .IMG_W(AW), .IMG_H(AH), .PIX_W(8), .ADDR_W(5), .WRITE_BORDER(1)
   ) dutA (
      .clk(clk), .reset(resetA), .gray_ready(readyA), .mode(modeA), .thr(thrA),
      .gray_req(reqA), .gray_addr(addrA), .gray_data(dataA),
      .lbp_valid(validA), .lbp_addr(waddrA), .lbp_data(wdataA), .finish(finishA)
   );

   lbp_engine_param #(
      .IMG_W(BW), .IMG_H(BH), .PIX_W(8), .ADDR_W(5), .WRITE_BORDER(0)
   ) dutB (
      .clk(clk), .reset(resetB), .gray_ready(readyB), .mode(modeB), .thr(thrB),
      .gray_req(reqB), .gray_addr(addrB), .gray_data(dataB),
      .lbp_valid(validB), .lbp_addr(waddrB), .lbp_data(wdataB), .finish(finishB)
   );

   // Gray memories answer the current address within the request cycle.
   always_comb begin
      dataA = (int'(addrA) < AW * AH) ? grayA[addrA] : 8'h00;
      dataB = (int'(addrB) < BW * BH) ? grayB[addrB] : 8'h00;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to the falling edge and act as both result memories.
   task automatic tick();
      @(negedge clk);
      cycle++;
      if (validA) begin
         lbpA[waddrA] = wdataA;
         wcntA[waddrA]++;
         if (int'(waddrA) <= lastWA) orderErrA++;
         lastWA     = int'(waddrA);
         lastWrCycA = cycle;
      end
      if (reqA && !readyA) stallErrA++;
      if (reqA && readyA) readCntA++;
      if (finishA && finCycA < 0) finCycA = cycle;
      if (validB) begin
         lbpB[waddrB] = wdataB;
         wcntB[waddrB]++;
         if (int'(waddrB) <= lastWB) orderErrB++;
         lastWB     = int'(waddrB);
         lastWrCycB = cycle;
      end
      if (reqB && readyB) readCntB++;
      if (finishB && finCycB < 0) finCycB = cycle;
   endtask

   // Reference LBP from the whole image; bit i uses neighbour i in raster
   // order around the centre.
   function automatic logic [7:0] refLbp(input img_t img, input int w,
                                         input int y, input int x,
                                         input logic m, input logic [7:0] t);
      int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
      int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
      int lim;
      logic [7:0] code;
      code = 8'h00;
      lim  = int'(img[y * w + x]) + (m ? int'(t) : 0);
      for (int i = 0; i < 8; i++) begin
         if (int'(img[(y + dy[i]) * w + x + dx[i]]) >= lim) code[i] = 1'b1;
      end
      return code;
   endfunction

   task automatic pulseResetA();
      readyA = 1'b0;
      resetA = 1'b1;
      tick();
      resetA = 1'b0;
      tick();
   endtask

   task automatic pulseResetB();
      readyB = 1'b0;
      resetB = 1'b1;
      tick();
      resetB = 1'b0;
      tick();
   endtask

   // Run one frame on dutA, optionally dropping gray_ready for 7 cycles,
   // then check the complete result image and the frame timing.
   task automatic applyStimulus(input logic m, input logic [7:0] t, input int stallAt);
      int n;
      logic [7:0] exp;
      for (int i = 0; i < 32; i++) begin
         lbpA[i]  = 8'hAA;
         wcntA[i] = 0;
      end
      lastWA = -1; orderErrA = 0; stallErrA = 0; readCntA = 0;
      lastWrCycA = -1; finCycA = -1;
      modeA = m; thrA = t; readyA = 1'b1;
      n = 0;
      while (!finishA && n < BOUND_A + 20) begin
         if (n == stallAt) readyA = 1'b0;
         if (n == stallAt + 7) readyA = 1'b1;
         tick();
         n++;
         if (n == 1) begin
            modeA = ~m;
            thrA  = t + 8'd77;
         end
      end
      checkOutput("A finish", finishA, 1);
      checkOutput("A cycles in bound", n <= BOUND_A + ((stallAt >= 0) ? 7 : 0), 1);
      checkOutput("A finish latency", finCycA - lastWrCycA, 1);
      checkOutput("A write order", orderErrA, 0);
      checkOutput("A gray_req in stall", stallErrA, 0);
      checkOutput("A read count", readCntA, (AH - 2) * AW * 3);
      for (int a = 0; a < AW * AH; a++) begin
         int y = a / AW;
         int x = a % AW;
         if (y == 0 || y == AH - 1 || x == 0 || x == AW - 1) exp = 8'h00;
         else exp = refLbp(grayA, AW, y, x, m, t);
         checkOutput($sformatf("A lbp[%0d]", a), lbpA[a], exp);
         checkOutput($sformatf("A writes[%0d]", a), wcntA[a], 1);
      end
      for (int i = 0; i < 4; i++) begin
         readyA = i[0];
         tick();
         checkOutput("A finish held", finishA, 1);
         checkOutput("A no write in done", validA, 0);
      end
   endtask

   // Run one frame on dutB (no border writes) and check every entry.
   task automatic applyStimulusB(input logic m, input logic [7:0] t,
                                 input logic [7:0] expInterior);
      int n;
      for (int i = 0; i < 32; i++) begin
         lbpB[i]  = 8'hAA;
         wcntB[i] = 0;
      end
      lastWB = -1; orderErrB = 0; readCntB = 0; lastWrCycB = -1; finCycB = -1;
      modeB = m; thrB = t; readyB = 1'b1;
      n = 0;
      while (!finishB && n < BOUND_B + 20) begin
         tick();
         n++;
      end
      checkOutput("B finish", finishB, 1);
      checkOutput("B cycles in bound", n <= BOUND_B, 1);
      checkOutput("B finish latency", finCycB - lastWrCycB, 1);
      checkOutput("B write order", orderErrB, 0);
      checkOutput("B read count", readCntB, (BH - 2) * BW * 3);
      for (int a = 0; a < BW * BH; a++) begin
         int y = a / BW;
         int x = a % BW;
         if (y == 0 || y == BH - 1 || x == 0 || x == BW - 1) begin
            checkOutput($sformatf("B border[%0d]", a), lbpB[a], 8'hAA);
            checkOutput($sformatf("B border writes[%0d]", a), wcntB[a], 0);
         end else begin
            checkOutput($sformatf("B lbp[%0d]", a), lbpB[a], expInterior);
            checkOutput($sformatf("B writes[%0d]", a), wcntB[a], 1);
         end
      end
   endtask

   initial begin
      cycle  = 0;
      resetA = 1'b1; readyA = 1'b0; modeA = 1'b0; thrA = 8'h00;
      resetB = 1'b1; readyB = 1'b0; modeB = 1'b0; thrB = 8'h00;

      // Image A: filler values plus two hand-checked neighbourhoods,
      // centre (1,1)=addr 7 and centre (3,4)=addr 22.
      for (int a = 0; a < 32; a++) grayA[a] = 8'((a * 37 + 11) % 200);
      grayA[0]  = 8'd10; grayA[1]  = 8'd20; grayA[2]  = 8'd30;
      grayA[6]  = 8'd40; grayA[7]  = 8'd25; grayA[8]  = 8'd50;
      grayA[12] = 8'd5;  grayA[13] = 8'd25; grayA[14] = 8'd60;
      grayA[15] = 8'd255; grayA[16] = 8'd255; grayA[17] = 8'd255;
      grayA[21] = 8'd255; grayA[22] = 8'd250; grayA[23] = 8'd255;
      grayA[27] = 8'd255; grayA[28] = 8'd255; grayA[29] = 8'd255;
      // Image B: ramp equal to the pixel address.
      for (int a = 0; a < 32; a++) grayB[a] = 8'(a);

      tick();
      tick();
      checkOutput("A reset gray_req", reqA, 0);
      checkOutput("A reset gray_addr", addrA, 0);
      checkOutput("A reset lbp_valid", validA, 0);
      checkOutput("A reset lbp_addr", waddrA, 0);
      checkOutput("A reset lbp_data", wdataA, 0);
      checkOutput("A reset finish", finishA, 0);
      checkOutput("B reset finish", finishB, 0);
      resetA = 1'b0;
      resetB = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("A idle gray_req", reqA, 0);
         checkOutput("A idle lbp_valid", validA, 0);
      end

      $display("[TB] frame A: mode 0, stall of 7 cycles mid-row");
      applyStimulus(1'b0, 8'd0, 15);
      checkOutput("A centre7 mode0", lbpA[7], 8'hDC);
      checkOutput("A centre22 mode0", lbpA[22], 8'hFF);

      $display("[TB] frame A: mode 1, thr 5");
      pulseResetA();
      applyStimulus(1'b1, 8'd5, -1);
      checkOutput("A centre7 thr5", lbpA[7], 8'h9C);
      checkOutput("A centre22 thr5", lbpA[22], 8'hFF);

      $display("[TB] frame A: reset mid-frame, then mode 1, thr 10");
      pulseResetA();
      modeA = 1'b1; thrA = 8'd10; readyA = 1'b1;
      repeat (25) tick();
      resetA = 1'b1;
      tick();
      checkOutput("A midreset gray_req", reqA, 0);
      checkOutput("A midreset gray_addr", addrA, 0);
      checkOutput("A midreset lbp_valid", validA, 0);
      checkOutput("A midreset lbp_addr", waddrA, 0);
      checkOutput("A midreset lbp_data", wdataA, 0);
      checkOutput("A midreset finish", finishA, 0);
      readyA = 1'b0;
      tick();
      resetA = 1'b0;
      tick();
      applyStimulus(1'b1, 8'd10, -1);
      checkOutput("A centre7 thr10", lbpA[7], 8'h98);
      checkOutput("A centre22 thr10", lbpA[22], 8'h00);

      $display("[TB] frame B: no border writes, mode 0 and mode 1");
      applyStimulusB(1'b0, 8'd0, 8'hF0);
      pulseResetB();
      applyStimulusB(1'b1, 8'd5, 8'hC0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/lbp_engine_param.md
Name: lbp_engine_param

Overview:
- Parametrised successor to the fixed 128x128 LBP engine.
- Fetches 8-neighbour 3x3 windows from gray memory through the existing req/addr/data protocol. Writes one LBP code per centre pixel to lbp memory.
- Adds runtime image geometry via parameters, pixel width, a thresholded-compare mode, explicit border writes, and stall on gray_ready.
- Sits between the gray image memory and the lbp result memory. Asserts finish when the frame is complete.

Parameters:
- IMG_W, 128, image width in pixels (>=3)
- IMG_H, 128, image height in pixels (>=3)
- PIX_W, 8, gray and LBP pixel width; LBP code is always 8 bits
- ADDR_W, 14, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- WRITE_BORDER, 1, 1 = write 0 to every border pixel; 0 = border addresses never written

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- gray_ready  input  1  source ready; starts the frame and gates every read
- mode  input  1  0 = standard compare (g_p >= g_c); 1 = thresholded compare (g_p >= g_c + thr)
- thr  input  PIX_W  threshold for mode 1; latched together with mode at frame start
- gray_req  output  1  read request for the current gray_addr
- gray_addr  output  ADDR_W  read address, y*IMG_W + x
- gray_data  input  PIX_W  read data; valid at the rising edge that ends a gray_req=1 cycle
- lbp_valid  output  1  write strobe; memory captures on the falling edge
- lbp_addr  output  ADDR_W  write address
- lbp_data  output  8  LBP code
- finish  output  1  frame done; held high until reset

Behaviour:
- Clock and reset: single clock domain. Synchronous active-high reset.
- Reset values: gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0. FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame. No further writes occur and a fresh frame starts on the next gray_ready.
- FSM states: IDLE -> (gray_ready=1; latch mode/thr) -> TOP -> ROW_FETCH <-> ROW_WRITE -> BOT -> DONE.
- TOP and BOT states (WRITE_BORDER=1 only):
  - Write 0 to each pixel of row 0 (TOP) or row IMG_H-1 (BOT), one per cycle.
  - These states are skipped when WRITE_BORDER=0.
- ROW_FETCH, for each interior row y = 1..IMG_H-2:
  - For each column x = 0..IMG_W-1, issue 3 reads in order (y-1,x), (y,x), (y+1,x), one per cycle, with gray_req=1.
  - Shift the fetched column into a 3-column window register.
- ROW_WRITE:
  - Once columns x-2..x are held (x >= 2), emit a single-cycle lbp_valid for centre (y, x-1).
  - The write overlaps the first read of the next column; no extra cycle is spent.
  - With WRITE_BORDER=1, column 0 of row y is written 0 before (y,1), and column IMG_W-1 is written 0 after (y,IMG_W-2).
  - Border writes may occupy a cycle with no read.
- Write order is strictly increasing raster order, and each address is written exactly once. With WRITE_BORDER=0, only interior addresses are written.
- Bit weights:
  - Top row (y-1), left to right: 1, 2, 4.
  - Middle row (y): left 8, right 16.
  - Bottom row (y+1), left to right: 32, 64, 128.
- Compare arithmetic: computed in PIX_W+1 bits with no wrap. In mode 1, if g_c+thr > 2^PIX_W-1, every bit is 0. thr=0 in mode 1 is identical to mode 0.
- Stall: when gray_ready=0 outside IDLE/DONE, gray_req=0 and the FSM, counters and window hold. No read is consumed, and pending writes are delayed until gray_ready returns.
- Completion: finish rises in the cycle after the last write and stays high. gray_ready is ignored in DONE.
- Throughput: with gray_ready held high, finish asserts within (IMG_H-2)*(3*IMG_W+4) + 2*IMG_W + 8 cycles of leaving IDLE.
- gray_addr changes only on rising edges and is stable during the whole gray_req cycle.

Test Plan:
- 3x3 image [10,20,30;40,25,50;5,25,60], mode 0, WRITE_BORDER=1 -> addr 4 = 0xDC; addrs 0-3 and 5-8 = 0x00; finish rises and stays high.
- Same image, mode 1, thr=5 -> addr 4 = 0x9C.
- Same image with centre 250, all neighbours 255, mode 1, thr=10 -> addr 4 = 0x00 (saturation); with thr=5 -> 0xFF.
- 128x128 pattern1, mode 0, default parameters -> all 16384 entries match golden1. Write addresses strictly increasing; finish is within the bound.
- WRITE_BORDER=0, lbp memory preset to 0xAA, 5x4 ramp image -> all border entries remain 0xAA; all 6 interior entries are correct.
- Stall and reset mid-frame:
  - gray_ready dropped for 7 cycles mid-row -> gray_req=0 throughout the drop; final image is identical to the unstalled run.
  - reset pulsed mid-frame -> all outputs 0 next cycle; a rerun produces the correct full image.
